pc_sequencer: RTL and testbench

- Control FSM for the fetch stage.
- Drives PC_ENB, FLUSH, BRANCH, JUMP_SEL and POP_L_H into fetch every cycle.
- Sequences the multi-cycle RET/RTI return-address pop (high word, then low word), interrupt entry (two-word PC push, then jump to ISR), decode jumps, execute branches and hazard stalls.
- Sits between the decode/hazard units and fetch; the only block allowed to redirect the PC.

---
 rtl/pc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage control FSM: PC enable/flush/redirect, RET/RTI return-address pop and interrupt PC push.
// Optional wait timeout on pop/push handshakes is compiled in with `define PC_SEQ_TIMEOUT_EN.
module pc_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_d,
    input  logic       jmp_d,
    input  logic       br_taken_e,
    input  logic       ret_d,
    input  logic       int_req,
    input  logic       wd_valid,
    input  logic       push_ack,
    output logic       PC_ENB,
    output logic       FLUSH,
    output logic       BRANCH,
    output logic [1:0] JUMP_SEL,
    output logic [1:0] POP_L_H,
    output logic       push_req,
    output logic       push_hi,
    output logic       int_ack,
    output logic       err,
    output logic [2:0] state_dbg
);

    // Word width only shapes the datapath fed by JUMP_SEL/POP_L_H; nothing here is W wide.
    localparam int unused_pc_w = 2 * W + TIMEOUT;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP_H   = 3'd1,
        POP_L   = 3'd2,
        RET_LD  = 3'd3,
        PUSH_H  = 3'd4,
        PUSH_L  = 3'd5,
        INT_JMP = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   timeout_hit;
    logic   timed_out;

    assign state_dbg = state;

    // Handshakes (valid/ready style): wd_valid is only consumed in POP_H/POP_L and push_ack
    // only in PUSH_H/PUSH_L; a pulse seen in any other state is dropped with no side effect.
    always_comb begin
        state_nxt = state;
        PC_ENB    = 1'b1;
        FLUSH     = 1'b0;
        BRANCH    = 1'b0;
        JUMP_SEL  = 2'b00;
        POP_L_H   = 2'b00;
        push_req  = 1'b0;
        push_hi   = 1'b0;
        int_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (br_taken_e) begin
                    BRANCH = 1'b1;
                    FLUSH  = 1'b1;
                end else if (ret_d) begin
                    PC_ENB    = 1'b0;
                    FLUSH     = 1'b1;
                    state_nxt = POP_H;
                end else if (int_req && !stall_d) begin
                    PC_ENB    = 1'b0;
                    FLUSH     = 1'b1;
                    state_nxt = PUSH_H;
                end else if (jmp_d) begin
                    JUMP_SEL = 2'b01;
                    FLUSH    = 1'b1;
                end else if (stall_d) begin
                    PC_ENB = 1'b0;
                end
            end
            POP_H: begin
                PC_ENB = 1'b0;
                FLUSH  = 1'b1;
                if (wd_valid) begin
                    POP_L_H   = 2'b11;
                    state_nxt = POP_L;
                end
            end
            POP_L: begin
                PC_ENB = 1'b0;
                FLUSH  = 1'b1;
                if (wd_valid) begin
                    POP_L_H   = 2'b10;
                    state_nxt = RET_LD;
                end
            end
            RET_LD: begin
                JUMP_SEL  = 2'b11;
                FLUSH     = 1'b1;
                state_nxt = IDLE;
            end
            PUSH_H: begin
                PC_ENB   = 1'b0;
                FLUSH    = 1'b1;
                push_req = 1'b1;
                push_hi  = 1'b1;
                if (push_ack) state_nxt = PUSH_L;
            end
            PUSH_L: begin
                PC_ENB   = 1'b0;
                FLUSH    = 1'b1;
                push_req = 1'b1;
                if (push_ack) state_nxt = INT_JMP;
            end
            INT_JMP: begin
                JUMP_SEL  = 2'b10;
                FLUSH     = 1'b1;
                int_ack   = !timed_out;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout_hit) state_nxt = INT_JMP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef PC_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          got_word;

    assign waiting     = (state == POP_H) || (state == POP_L) ||
                         (state == PUSH_H) || (state == PUSH_L);
    assign got_word    = ((state == POP_H) || (state == POP_L)) ? wd_valid : push_ack;
    assign timeout_hit = waiting && !got_word && (wait_cnt == CW'(TIMEOUT));

    // Counter restarts on every state change, so each wait state gets a fresh budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (state_nxt != state) wait_cnt <= '0;
            else if (waiting)       wait_cnt <= wait_cnt + 1'b1;
            timed_out <= timeout_hit;
            err       <= err | timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: IDLE decision table plus RET, interrupt,
// interlock, reset and (with PC_SEQ_TIMEOUT_EN) timeout sequences.
module tb_pc_sequencer;

    localparam int OW = 11;
    localparam logic [2:0] S_IDLE = 3'd0, S_POP_H = 3'd1, S_POP_L = 3'd2, S_RET_LD = 3'd3,
                           S_PUSH_H = 3'd4, S_PUSH_L = 3'd5;

    logic clk = 1'b0;
    logic rst;
    logic stall_d, jmp_d, br_taken_e, ret_d, int_req, wd_valid, push_ack;
    logic PC_ENB, FLUSH, BRANCH, push_req, push_hi, int_ack, err;
    logic [1:0] JUMP_SEL, POP_L_H;
    logic [2:0] state_dbg;

    logic [OW-1:0] exp_q[$];
    string         name_q[$];
    int checks = 0;
    int errors = 0;
    logic err_exp = 1'b0;

    typedef struct {
        logic [4:0]    req;   // {br_taken_e, jmp_d, ret_d, int_req, stall_d}
        logic          wdv;
        logic          pack;
        logic [OW-1:0] exp;
        logic [2:0]    nxt;
        string         name;
    } vec_t;
    vec_t vecs[12];

    pc_sequencer #(.W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .jmp_d(jmp_d), .br_taken_e(br_taken_e),
        .ret_d(ret_d), .int_req(int_req), .wd_valid(wd_valid), .push_ack(push_ack),
        .PC_ENB(PC_ENB), .FLUSH(FLUSH), .BRANCH(BRANCH), .JUMP_SEL(JUMP_SEL),
        .POP_L_H(POP_L_H), .push_req(push_req), .push_hi(push_hi), .int_ack(int_ack),
        .err(err), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [OW-1:0] mk(input logic pc, input logic fl, input logic br,
                                         input logic [1:0] js, input logic [1:0] plh,
                                         input logic rq, input logic hi, input logic ia);
        return {pc, fl, br, js, plh, rq, hi, ia, err_exp};
    endfunction

    // Scoreboard
    task automatic check_out();
        logic [OW-1:0] act;
        logic [OW-1:0] e;
        string n;
        act = {PC_ENB, FLUSH, BRANCH, JUMP_SEL, POP_L_H, push_req, push_hi, int_ack, err};
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pc_enb,flush,branch,jsel2,pop2,preq,phi,iack,err)",
                     n, act, e);
        end
    endtask

    task automatic check_state(input logic [2:0] exp_s, input string n);
        @(posedge clk);
        #1;
        checks++;
        if (state_dbg !== exp_s) begin
            errors++;
            $display("FAIL %s_state: got %0d expected %0d", n, state_dbg, exp_s);
        end
    endtask

    // Drivers
    task automatic step(input logic [4:0] req, input logic wdv, input logic pack,
                        input logic [OW-1:0] exp, input string n);
        @(negedge clk);
        {br_taken_e, jmp_d, ret_d, int_req, stall_d} = req;
        wd_valid = wdv;
        push_ack = pack;
        exp_q.push_back(exp);
        name_q.push_back(n);
        #2;
        check_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        {br_taken_e, jmp_d, ret_d, int_req, stall_d, wd_valid, push_ack} = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    logic [OW-1:0] dflt, wait_o, push_h_o, push_l_o, int_o;

    initial begin
        rst = 1'b1;
        {br_taken_e, jmp_d, ret_d, int_req, stall_d, wd_valid, push_ack} = '0;
        dflt     = mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        wait_o   = mk(0, 1, 0, 2'b00, 2'b00, 0, 0, 0);
        push_h_o = mk(0, 1, 0, 2'b00, 2'b00, 1, 1, 0);
        push_l_o = mk(0, 1, 0, 2'b00, 2'b00, 1, 0, 0);
        int_o    = mk(1, 1, 0, 2'b10, 2'b00, 0, 0, 1);

        vecs[0]  = '{5'b00000, 0, 0, dflt, S_IDLE, "idle_none"};
        vecs[1]  = '{5'b10000, 0, 0, mk(1, 1, 1, 2'b00, 2'b00, 0, 0, 0), S_IDLE, "br_only"};
        vecs[2]  = '{5'b11111, 0, 0, mk(1, 1, 1, 2'b00, 2'b00, 0, 0, 0), S_IDLE, "br_over_all"};
        vecs[3]  = '{5'b01110, 0, 0, wait_o, S_POP_H, "ret_over_int_jmp"};
        vecs[4]  = '{5'b01010, 0, 0, wait_o, S_PUSH_H, "int_over_jmp"};
        vecs[5]  = '{5'b00011, 0, 0, mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0), S_IDLE, "int_blocked_by_stall"};
        vecs[6]  = '{5'b01011, 0, 0, mk(1, 1, 0, 2'b01, 2'b00, 0, 0, 0), S_IDLE, "jmp_over_stalled_int"};
        vecs[7]  = '{5'b01000, 0, 0, mk(1, 1, 0, 2'b01, 2'b00, 0, 0, 0), S_IDLE, "jmp_only"};
        vecs[8]  = '{5'b00001, 0, 0, mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0), S_IDLE, "stall_only"};
        vecs[9]  = '{5'b01001, 0, 0, mk(1, 1, 0, 2'b01, 2'b00, 0, 0, 0), S_IDLE, "jmp_over_stall"};
        vecs[10] = '{5'b00000, 1, 0, dflt, S_IDLE, "stray_wd_valid"};
        vecs[11] = '{5'b00000, 0, 1, dflt, S_IDLE, "stray_push_ack"};

        // Reset state while rst is held
        #1;
        exp_q.push_back(dflt);
        name_q.push_back("reset_held");
        check_out();
        #11;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(5'b00000, 0, 0, dflt, "post_reset_idle");

        // IDLE decision table
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].req, vecs[i].wdv, vecs[i].pack, vecs[i].exp, vecs[i].name);
            check_state(vecs[i].nxt, vecs[i].name);
            if (vecs[i].nxt != S_IDLE) do_reset();
        end

        // Priority: all requests, then ret alone
        step(5'b11110, 0, 0, mk(1, 1, 1, 2'b00, 2'b00, 0, 0, 0), "prio_all");
        check_state(S_IDLE, "prio_all");
        step(5'b00100, 0, 0, wait_o, "prio_ret_next");
        check_state(S_POP_H, "prio_ret_next");

        // Asynchronous reset mid-sequence
        @(negedge clk);
        ret_d = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        exp_q.push_back(dflt);
        name_q.push_back("async_reset");
        check_out();
        checks++;
        if (state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL async_reset_state: got %0d expected %0d", state_dbg, S_IDLE);
        end
        #1;
        rst = 1'b0;

        // RET with interrupt held throughout; interrupt taken once back in IDLE
        step(5'b00100, 0, 0, wait_o, "ret_issue");
        step(5'b10010, 0, 0, wait_o, "pop_h_ignore_reqs");
        step(5'b00010, 0, 1, wait_o, "pop_h_stray_ack");
        step(5'b00010, 1, 0, mk(0, 1, 0, 2'b00, 2'b11, 0, 0, 0), "pop_hi_word");
        check_state(S_POP_L, "pop_hi_word");
        step(5'b00010, 0, 0, wait_o, "pop_l_wait");
        step(5'b00010, 1, 0, mk(0, 1, 0, 2'b00, 2'b10, 0, 0, 0), "pop_lo_word");
        check_state(S_RET_LD, "pop_lo_word");
        step(5'b00010, 0, 0, mk(1, 1, 0, 2'b11, 2'b00, 0, 0, 0), "ret_load");
        step(5'b00010, 0, 0, wait_o, "int_after_ret");
        check_state(S_PUSH_H, "int_after_ret");
        step(5'b00000, 1, 0, push_h_o, "push_h_stray_wd");
        step(5'b00000, 0, 1, push_h_o, "push_h_ack");
        check_state(S_PUSH_L, "push_h_ack");
        step(5'b00000, 0, 1, push_l_o, "push_l_ack");
        step(5'b00000, 0, 0, int_o, "int_jump");
        step(5'b00000, 0, 0, dflt, "idle_after_int");

        // Stall/interrupt interlock
        step(5'b00011, 0, 0, mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0), "interlock_stalled");
        check_state(S_IDLE, "interlock_stalled");
        step(5'b00010, 0, 0, wait_o, "interlock_release");
        check_state(S_PUSH_H, "interlock_release");
        step(5'b00000, 0, 1, push_h_o, "interlock_push_h");
        step(5'b00000, 0, 1, push_l_o, "interlock_push_l");
        step(5'b00000, 0, 0, int_o, "interlock_int_jump");

`ifdef PC_SEQ_TIMEOUT_EN
        // Pop never answered: abort to ISR after TIMEOUT+1 cycles in POP_H
        step(5'b00100, 0, 0, wait_o, "to_ret_issue");
        for (int k = 0; k < 5; k++) step(5'b00000, 0, 0, wait_o, "to_pop_wait");
        err_exp = 1'b1;
        step(5'b00000, 0, 0, mk(1, 1, 0, 2'b10, 2'b00, 0, 0, 0), "to_abort_jump");
        step(5'b00000, 0, 0, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0), "to_err_sticky");
        step(5'b00000, 0, 0, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0), "to_err_sticky2");
        do_reset();
        err_exp = 1'b0;
        step(5'b00000, 0, 0, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0), "to_err_cleared");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
